// File: rtl/sr_ff_pkg.sv
// -----------------------------------------------------------------------------
// sr_ff_pkg
// Shared types and next-state rule for the sr_ff_bank flip-flop bank.
//   sr_mode_e : resolution applied when S and R are both high on an edge.
//   sr_next() : next state of a single SR bit given its current state,
//               set, reset and the resolution mode.
// -----------------------------------------------------------------------------
package sr_ff_pkg;

    typedef enum logic [1:0] {
        SR_HOLD    = 2'd0,
        SR_SET_PRI = 2'd1,
        SR_RST_PRI = 2'd2,
        SR_TOGGLE  = 2'd3
    } sr_mode_e;

    function automatic logic sr_next(
        input logic     q,
        input logic     s,
        input logic     r,
        input sr_mode_e mode
    );
        logic result;
        // NOTE: result gets a value before any branch so every path through
        // the function is defined; the same habit keeps always_comb latch-free.
        result = q;
        unique case ({s, r})
            2'b10:   result = 1'b1;
            2'b01:   result = 1'b0;
            2'b11: begin
                unique case (mode)
                    SR_HOLD:    result = q;
                    SR_SET_PRI: result = 1'b1;
                    SR_RST_PRI: result = 1'b0;
                    SR_TOGGLE:  result = ~q;
                    default:    result = q;
                endcase
            end
            default: result = q;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/sr_ff_cell.sv
// -----------------------------------------------------------------------------
// sr_ff_cell
// One edge-triggered SR flip-flop with enable and a registered change flag.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset, loads INIT_BIT
//   en   - enable; when low the bit holds
//   s, r - set / reset inputs
//   mode - resolution when s and r are both high
//   q    - stored bit
//   chg  - high for one cycle after an edge on which q changed
// -----------------------------------------------------------------------------
module sr_ff_cell
    import sr_ff_pkg::*;
#(
    parameter logic INIT_BIT = 1'b0
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     en,
    input  logic     s,
    input  logic     r,
    input  sr_mode_e mode,
    output logic     q,
    output logic     chg
);

    logic q_next;

    always_comb begin
        q_next = q;
        if (en) begin
            q_next = sr_next(q, s, r, mode);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; chg relies on seeing the old q here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q   <= INIT_BIT;
            chg <= 1'b0;
        end else begin
            q   <= q_next;
            chg <= q_next ^ q;
        end
    end

endmodule

// File: rtl/sr_ff_bank.sv
// -----------------------------------------------------------------------------
// sr_ff_bank
// Bank of WIDTH clocked SR flip-flops with shared clock and enable, run-time
// S=R=1 resolution, per-bit change pulses and conflict detection.
// Optional feature macro: SR_FF_BANK_CONFLICT_CNT_EN
//   defined   - conflict_cnt is a saturating count of conflicting enabled
//               edges, cleared synchronously by clr_cnt
//   undefined - no counter is built, conflict_cnt reads 0, clr_cnt is ignored
// Ports:
//   clk          - rising-edge clock
//   rst          - asynchronous active-high reset
//   E            - global enable
//   S, R         - per-channel set / reset
//   MODE         - S=R=1 resolution (0 hold, 1 set, 2 reset, 3 toggle)
//   clr_cnt      - synchronous clear of the conflict counter
//   Q, Q_L       - stored state and its complement
//   chg          - per-bit one-cycle pulse for bits that changed on last edge
//   conflict     - one-cycle pulse after an enabled edge with any S&R bit
//   conflict_cnt - saturating conflict count
// -----------------------------------------------------------------------------
module sr_ff_bank
    import sr_ff_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] INIT  = '0,
    parameter int               CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             E,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] R,
    input  logic [1:0]       MODE,
    input  logic             clr_cnt,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_L,
    output logic [WIDTH-1:0] chg,
    output logic             conflict,
    output logic [CNT_W-1:0] conflict_cnt
);

    sr_mode_e mode;
    logic     conflict_now;

    assign mode         = sr_mode_e'(MODE);
    assign conflict_now = E & (|(S & R));

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        sr_ff_cell #(
            .INIT_BIT (INIT[i])
        ) u_cell (
            .clk  (clk),
            .rst  (rst),
            .en   (E),
            .s    (S[i]),
            .r    (R[i]),
            .mode (mode),
            .q    (Q[i]),
            .chg  (chg[i])
        );
    end

    // Complement comes from the Q flops themselves, so Q and Q_L never agree.
    assign Q_L = ~Q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict <= 1'b0;
        end else begin
            conflict <= conflict_now;
        end
    end

`ifdef SR_FF_BANK_CONFLICT_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (clr_cnt) begin
            conflict_cnt <= '0;
        end else if (conflict_now && (conflict_cnt != {CNT_W{1'b1}})) begin
            conflict_cnt <= conflict_cnt + 1'b1;
        end
    end
`else
    logic unused_clr_cnt;

    assign unused_clr_cnt = clr_cnt;
    assign conflict_cnt   = '0;
`endif

endmodule

// File: tb/tb_sr_ff_bank.sv
// -----------------------------------------------------------------------------
// tb_sr_ff_bank
// Randomized and directed stimulus against a vector-level reference model.
// The driver pushes the expected post-edge response into a queue; a monitor
// pops one entry after each rising edge and compares it with the outputs.
// -----------------------------------------------------------------------------
module tb_sr_ff_bank;

    localparam int         WIDTH   = 8;
    localparam int         CNT_W   = 3;
    localparam logic [7:0] INIT    = 8'hA5;
    localparam int         CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] chg;
        logic             conf;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             E;
    logic [WIDTH-1:0] S;
    logic [WIDTH-1:0] R;
    logic [1:0]       MODE;
    logic             clr_cnt;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Q_L;
    logic [WIDTH-1:0] chg;
    logic             conflict;
    logic [CNT_W-1:0] conflict_cnt;

    int total = 0;
    int bad   = 0;

    exp_t             sb[$];
    logic [WIDTH-1:0] mq;
    int               mcnt;

    sr_ff_bank #(
        .WIDTH (WIDTH),
        .INIT  (INIT),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .E            (E),
        .S            (S),
        .R            (R),
        .MODE         (MODE),
        .clr_cnt      (clr_cnt),
        .Q            (Q),
        .Q_L          (Q_L),
        .chg          (chg),
        .conflict     (conflict),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one edge worth of inputs and queue the expected result.
    task automatic step(input logic e, input logic [WIDTH-1:0] s,
                        input logic [WIDTH-1:0] r, input logic [1:0] m,
                        input logic c);
        logic [WIDTH-1:0] both;
        logic [WIDTH-1:0] res;
        logic [WIDTH-1:0] qn;
        exp_t             x;
        @(negedge clk);
        E = e; S = s; R = r; MODE = m; clr_cnt = c;
        both = s & r;
        case (m)
            2'd0:    res = mq;
            2'd1:    res = '1;
            2'd2:    res = '0;
            default: res = ~mq;
        endcase
        qn     = e ? ((mq & ~s & ~r) | (s & ~r) | (both & res)) : mq;
        x.q    = qn;
        x.chg  = qn ^ mq;
        x.conf = e && (both != '0);
`ifdef SR_FF_BANK_CONFLICT_CNT_EN
        if (c) mcnt = 0;
        else if (x.conf && mcnt < CNT_MAX) mcnt = mcnt + 1;
`else
        mcnt = 0;
`endif
        x.cnt = CNT_W'(mcnt);
        mq    = qn;
        sb.push_back(x);
    endtask

    task automatic check_reset_state(input string tag);
        logic [WIDTH-1:0] ql_exp;
        ql_exp = ~INIT;
        check({tag, "_q"},    32'(Q),            32'(INIT));
        check({tag, "_q_l"},  32'(Q_L),          32'(ql_exp));
        check({tag, "_chg"},  32'(chg),          32'd0);
        check({tag, "_conf"}, 32'(conflict),     32'd0);
        check({tag, "_cnt"},  32'(conflict_cnt), 32'd0);
    endtask

    // Monitor: outputs are valid one edge after each queued stimulus.
    always @(posedge clk) begin
        exp_t             x;
        logic [WIDTH-1:0] ql_exp;
        #1;
        if (sb.size() > 0) begin
            x      = sb.pop_front();
            ql_exp = ~x.q;
            check("q",        32'(Q),            32'(x.q));
            check("q_l",      32'(Q_L),          32'(ql_exp));
            check("chg",      32'(chg),          32'(x.chg));
            check("conflict", 32'(conflict),     32'(x.conf));
            check("cnt",      32'(conflict_cnt), 32'(x.cnt));
        end
    end

    initial begin
        int wait_cycles;
        rst = 1'b1; E = 1'b0; S = '0; R = '0; MODE = 2'd0; clr_cnt = 1'b0;
        mq = INIT; mcnt = 0;
        #1;
        check_reset_state("reset_init");
        @(negedge clk);
        rst = 1'b0;

        // Basic set/reset from zero, then hold.
        step(1'b1, 8'h00, 8'hFF, 2'd0, 1'b0);
        step(1'b1, 8'h0F, 8'hF0, 2'd0, 1'b0);
        step(1'b1, 8'h00, 8'h00, 2'd0, 1'b0);

        // Conflict modes on bit 0, starting from Q[0]=0.
        step(1'b1, 8'h00, 8'h01, 2'd0, 1'b0);
        step(1'b1, 8'h01, 8'h01, 2'd0, 1'b0);
        step(1'b1, 8'h01, 8'h01, 2'd1, 1'b0);
        step(1'b1, 8'h01, 8'h01, 2'd2, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 8'h01, 8'h01, 2'd3, 1'b0);

        // Enable gating.
        for (int i = 0; i < 5; i++) step(1'b0, 8'hFF, 8'h00, 2'd1, 1'b0);

        // Counter saturation, then clear together with a conflict.
        step(1'b1, 8'h00, 8'h00, 2'd0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, 8'h81, 8'h81, 2'd0, 1'b0);
        step(1'b1, 8'h81, 8'h81, 2'd0, 1'b1);
        step(1'b0, 8'h81, 8'h81, 2'd0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 7) != 0),
                 WIDTH'($urandom), WIDTH'($urandom),
                 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 15) == 0));
        end

        // Asynchronous reset mid-run with Q=FF, checked before any edge.
        step(1'b1, 8'hFF, 8'h00, 2'd0, 1'b0);
        step(1'b1, 8'h10, 8'h10, 2'd0, 1'b0);
        @(posedge clk);
        #3;
        E = 1'b0;
        rst = 1'b1;
        mq = INIT; mcnt = 0;
        #1;
        check_reset_state("reset_mid");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 40; i++) begin
            step(1'b1, WIDTH'($urandom), WIDTH'($urandom),
                 2'($urandom_range(0, 3)), 1'b0);
        end

        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 20) begin
            @(negedge clk);
            wait_cycles++;
        end
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
